counter_ctrl: RTL and testbench

Controller and datapath for the cascaded nibble counter chain: sequences a chain of NIBBLES 4-bit counter stages, which form one wide counter through the ripple-carry (cout→cin) hookup the counter units already use. It accepts load / terminal-count / start / stop commands over a valid/ready port, paces counting with a prescaler, and reports terminal count, wrap and FSM state. It replaces free-running counter units wherever software or a higher FSM must own the count.

---
 rtl/counter_ctrl_pkg.sv | 6 +
 rtl/counter_nibble.sv | 24 ++
 rtl/counter_ctrl.sv | 110 +++++++++++
 tb/tb_counter_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the nibble counter controller.
package counter_ctrl_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_SET_TC, OP_START, OP_STOP} op_e;
endpackage

// File: rtl/counter_nibble.sv
// counter_nibble: one 4-bit ripple-carry counter stage.
module counter_nibble
    import counter_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ld,
    input  logic [NIBBLE_W-1:0] d,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] q,
    output logic                cout
);
    logic [NIBBLE_W-1:0] q_q, q_d;

    always_comb q_d = ld ? d : (en && cin) ? q_q + 1'b1 : q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;

    assign q    = q_q;
    assign cout = cin && (q_q == '1);
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven controller for a chain of nibble counter stages,
// with prescaled ticks, terminal-count detection and wrap reporting.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter  int NIBBLES  = 2,
    parameter  int PRESCALE = 1,
    localparam int W        = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] count,
    output logic [1:0]   state,
    output logic         done,
    output logic         wrap
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  tc_q, tc_d, reload_q, reload_d, ld_val;
    logic          auto_q, auto_d, ready_q, ready_d, done_q, done_d, wrap_q, wrap_d;
    logic          acc, run, raw_tick, tick, hit, ld, is_load, is_start, is_stop;
    op_e           op;

    assign op       = op_e'(cmd_op);
    assign acc      = cmd_valid && ready_q;
    assign is_load  = acc && op == OP_LOAD;
    assign is_start = acc && op == OP_START;
    assign is_stop  = acc && op == OP_STOP;
    assign run      = state_q == ST_RUN;
    assign raw_tick = run && presc_q == PW'(PRESCALE - 1);
    // LOAD and STOP pre-empt a coincident tick entirely: no count, done or wrap.
    assign tick     = raw_tick && !is_load && !is_stop;
    assign hit      = count == tc_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (tick && hit && !auto_q) state_d = ST_DONE;
        else if (is_start)          state_d = ST_RUN;
        else if (is_stop)           state_d = run ? ST_HOLD : ST_IDLE;
    end

    always_comb begin
        ld     = is_load || (is_start && state_q == ST_DONE) || (tick && hit && auto_q);
        ld_val = is_load ? cmd_data : reload_q;
        done_d = tick && hit;
    end

    always_comb begin
        ready_d  = !acc;
        tc_d     = (acc && op == OP_SET_TC) ? cmd_data : tc_q;
        reload_d = is_load ? cmd_data : reload_q;
        auto_d   = is_start ? cmd_data[0] : auto_q;
        presc_d  = (is_start || raw_tick) ? '0 : run ? presc_q + 1'b1 : presc_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            presc_q  <= '0;
            tc_q     <= '1;
            reload_q <= '0;
            auto_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            tc_q     <= tc_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end

    // Per-stage carry nets keep the ripple chain free of a self-referencing vector.
    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        logic ci, co;
        if (i == 0) begin : g_first
            assign ci = tick;
        end else begin : g_rest
            assign ci = g_nib[i-1].co;
        end
        counter_nibble u_nib (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (!hit),
            .ld   (ld),
            .d    (ld_val[i*NIBBLE_W +: NIBBLE_W]),
            .cin  (ci),
            .q    (count[i*NIBBLE_W +: NIBBLE_W]),
            .cout (co)
        );
    end

    assign wrap_d    = g_nib[NIBBLES-1].co && !hit;
    assign cmd_ready = ready_q;
    assign state     = state_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: vector table, corner sequences and random stimulus against
// a behavioural model, on PRESCALE=1 and PRESCALE=3 instances sharing inputs.
module tb_counter_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rdy1, rdy3, dn1, dn3, wr1, wr3;
    logic [7:0] cnt1, cnt3;
    logic [1:0] st1, st3;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.NIBBLES(2), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .count(cnt1), .state(st1),
        .done(dn1), .wrap(wr1)
    );
    counter_ctrl #(.NIBBLES(2), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .count(cnt3), .state(st3),
        .done(dn3), .wrap(wr3)
    );

    typedef struct {
        int count, tc, reload, autor, st, presc;
        bit done, wrap, ready;
    } mst_t;

    mst_t m1, m3;

    function automatic mst_t mreset();
        mst_t m;
        m.count = 0; m.tc = 255; m.reload = 0; m.autor = 0; m.st = 0; m.presc = 0;
        m.done = 0; m.wrap = 0; m.ready = 1;
        return m;
    endfunction

    function automatic mst_t mstep(mst_t m, bit v, int op, int d, int p);
        mst_t n = m;
        bit acc = v && m.ready;
        bit tick = (m.st == 1) && (m.presc == p - 1) && !(acc && (op == 0 || op == 3));
        n.done = 0; n.wrap = 0; n.ready = !acc;
        if (m.st == 1) n.presc = (m.presc + 1) % p;
        if (tick) begin
            if (m.count == m.tc) begin
                n.done = 1;
                if (m.autor != 0) n.count = m.reload;
                else n.st = 3;
            end else begin
                n.count = (m.count + 1) % 256;
                n.wrap = (m.count == 255);
            end
        end
        if (acc) begin
            if (op == 0) begin n.count = d; n.reload = d; end
            if (op == 1) n.tc = d;
            if (op == 2) begin
                n.autor = d % 2;
                n.presc = 0;
                if (m.st == 3) n.count = m.reload;
                if (m.st != 1) n.st = 1;
            end
            if (op == 3) n.st = (m.st == 1) ? 2 : 0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("m1_count", cnt1, m1.count); chk("m1_state", st1, m1.st);
        chk("m1_done", dn1, m1.done);    chk("m1_wrap", wr1, m1.wrap);
        chk("m1_ready", rdy1, m1.ready);
        chk("m3_count", cnt3, m3.count); chk("m3_state", st3, m3.st);
        chk("m3_done", dn3, m3.done);    chk("m3_wrap", wr3, m3.wrap);
        chk("m3_ready", rdy3, m3.ready);
    endtask

    task automatic step(input bit v, input int op, input int d);
        cmd_valid = v; cmd_op = 2'(op); cmd_data = 8'(d);
        m1 = mstep(m1, v, op, d, 1);
        m3 = mstep(m3, v, op, d, 3);
        @(posedge clk); #1;
        cmp_model();
    endtask

    typedef struct {
        bit v; int op; int d;
        int c; int s; bit dn; bit wr; bit rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vec(bit v, int op, int d, int c, int s, bit dn, bit wr, bit rdy);
        vec_t t;
        t.v = v; t.op = op; t.d = d; t.c = c; t.s = s; t.dn = dn; t.wr = wr; t.rdy = rdy;
        return t;
    endfunction

    initial begin
        // PRESCALE=1 instance: load/tc/start one-shot, auto-reload, stop, wrap through tc.
        tbl.push_back(vec(1, 0, 'h0E, 'h0E, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0E, 0, 0, 0, 1));
        tbl.push_back(vec(1, 1, 'h12, 'h0E, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0E, 0, 0, 0, 1));
        tbl.push_back(vec(1, 2, 0,    'h0E, 1, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0F, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h10, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h11, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h12, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h12, 3, 1, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h12, 3, 0, 0, 1));
        tbl.push_back(vec(1, 2, 1,    'h0E, 1, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0F, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h10, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h11, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h12, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h0E, 1, 1, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h0F, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h10, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h11, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h12, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h0E, 1, 1, 0, 1));
        tbl.push_back(vec(1, 3, 0,    'h0E, 2, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0E, 2, 0, 0, 1));
        tbl.push_back(vec(1, 3, 0,    'h0E, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'h0E, 0, 0, 0, 1));
        tbl.push_back(vec(1, 0, 'hFD, 'hFD, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'hFD, 0, 0, 0, 1));
        tbl.push_back(vec(1, 1, 'h05, 'hFD, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'hFD, 0, 0, 0, 1));
        tbl.push_back(vec(1, 2, 0,    'hFD, 1, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0,    'hFE, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'hFF, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h00, 1, 0, 1, 1));
        tbl.push_back(vec(0, 0, 0,    'h01, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h02, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h03, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h04, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h05, 1, 0, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h05, 3, 1, 0, 1));
        tbl.push_back(vec(0, 0, 0,    'h05, 3, 0, 0, 1));

        m1 = mreset(); m3 = mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", cnt1, 0); chk("rst_state", st1, 0);
        chk("rst_ready", rdy1, 1); chk("rst_done", dn1, 0);
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].op, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), cnt1, tbl[i].c);
            chk($sformatf("tbl%0d_state", i), st1, tbl[i].s);
            chk($sformatf("tbl%0d_done", i), dn1, tbl[i].dn);
            chk($sformatf("tbl%0d_wrap", i), wr1, tbl[i].wr);
            chk($sformatf("tbl%0d_ready", i), rdy1, tbl[i].rdy);
        end

        // Asynchronous reset while running at 8'h37.
        step(1, 0, 'h36); step(0, 0, 0); step(1, 2, 0); step(0, 0, 0);
        chk("pre_rst_count", cnt1, 'h37);
        rst_n = 1'b0;
        #1;
        chk("arst_count", cnt1, 0); chk("arst_state", st1, 0);
        chk("arst_ready", rdy1, 1); chk("arst_done", dn1, 0);
        chk("arst_wrap", wr1, 0);  chk("arst_count3", cnt3, 0);
        m1 = mreset(); m3 = mreset();
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 0);

        // PRESCALE=3: stop after 7 cycles, then resume.
        step(1, 0, 'h20); step(0, 0, 0); step(1, 2, 0);
        repeat (6) step(0, 0, 0);
        step(1, 3, 0);
        chk("p3_stop_count", cnt3, 'h22); chk("p3_stop_state", st3, 2);
        repeat (3) step(0, 0, 0);
        chk("p3_hold_count", cnt3, 'h22);
        step(1, 2, 0);
        step(0, 0, 0); step(0, 0, 0);
        chk("p3_resume_wait", cnt3, 'h22);
        step(0, 0, 0);
        chk("p3_resume_tick", cnt3, 'h23);

        // cmd_valid held with LOAD while dut1 ticks every cycle.
        step(1, 0, 'hA0); chk("b2b_ready0", rdy1, 0); chk("b2b_count0", cnt1, 'hA0);
        step(1, 0, 'hB0); chk("b2b_ready1", rdy1, 1); chk("b2b_count1", cnt1, 'hA1);
        step(1, 0, 'hC0); chk("b2b_ready2", rdy1, 0); chk("b2b_count2", cnt1, 'hC0);
        step(1, 0, 'hD0); chk("b2b_ready3", rdy1, 1);

        for (int k = 0; k < 800; k++) begin
            int op = $urandom_range(0, 3);
            int d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            step($urandom_range(0, 3) == 0, op, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
